// File: rtl/mul32_seq_pkg.sv
// Shared definitions for the mul32_seq multiplier slice.
package mul32_seq_pkg;

  localparam int unsigned MUL32_WIDTH = 32;
  localparam int unsigned MUL32_ITER  = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul32_seq_cla32.sv
// cla32: 32-bit carry-lookahead adder, 4-bit lookahead groups with the
// group carry rippling between groups.
module cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s,
  output logic        co
);

  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] c;
  logic        carry;

  // Per-group lookahead carries, then the sum.
  always_comb begin
    g     = a & b;
    p     = a ^ b;
    c     = '0;
    carry = ci;
    for (int unsigned k = 0; k < 8; k++) begin
      c[4*k]   = carry;
      c[4*k+1] = g[4*k] | (p[4*k] & carry);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & carry);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & carry);
      carry    = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & carry);
    end
    s  = p ^ c;
    co = carry;
  end

endmodule

// File: rtl/mul32_seq.sv
// mul32_seq: sequential 32x32->64 unsigned shift-add multiplier using one cla32.
// Optional macro MUL32_EARLY_TERM_EN: finish as soon as the remaining
// multiplier bits are all zero.
module mul32_seq
  import mul32_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
);

  if (WIDTH != MUL32_WIDTH) begin : g_width_check
    $error("mul32_seq: WIDTH must be 32");
  end

  state_t               state;
  logic [WIDTH-1:0]     a_q;
  logic [2*WIDTH-1:0]   p_q;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     sum;
  logic                 co;
  logic [2*WIDTH-1:0]   p_step;
  logic                 last_iter;
  logic                 early;
  logic [2*WIDTH-1:0]   p_early;

  cla32 u_cla32 (
    .a  (p_q[2*WIDTH-1:WIDTH]),
    .b  (a_q),
    .ci (1'b0),
    .s  (sum),
    .co (co)
  );

  // One shift-add step: add the multiplicand when the current multiplier bit is set.
  always_comb begin
    p_step    = p_q[0] ? {co, sum, p_q[WIDTH-1:1]}
                       : {1'b0, p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1:1]};
    last_iter = (cnt == CNT_W'(MUL32_ITER - 1));
  end

`ifdef MUL32_EARLY_TERM_EN
  logic [WIDTH-1:0] rem_mask;
  logic [6:0]       sh_amt;

  // Remaining multiplier bits sit in P[31-cnt:0]; if they are all zero the
  // rest of the iterations are pure shifts, so collapse them into one.
  always_comb begin
    rem_mask = {WIDTH{1'b1}} >> cnt;
    sh_amt   = 7'd32 - 7'(cnt);
    early    = ((p_q[WIDTH-1:0] & rem_mask) == '0);
    p_early  = p_q >> sh_amt;
  end
`else
  // No early-termination path in this build.
  always_comb begin
    early   = 1'b0;
    p_early = '0;
  end
`endif

  // Control FSM, datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      a_q       <= '0;
      p_q       <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= a;
            p_q      <= {{WIDTH{1'b0}}, b};
            cnt      <= '0;
            state    <= ST_CALC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_CALC: begin
          cnt <= cnt + 1'b1;
          if (early) begin
            p_q       <= p_early;
            state     <= ST_DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            p_q <= p_step;
            if (last_iter) begin
              state     <= ST_DONE;
              busy      <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (out_valid && out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign p = p_q;

endmodule

// File: tb/tb_mul32_seq.sv
// Scoreboard bench for mul32_seq: driver pushes expected product and latency,
// monitor checks whenever out_valid is presented.
module tb_mul32_seq;

  typedef struct {
    logic [63:0] prod;
    int          lat;
    int          t0;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] p;
  logic        busy;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t sb[$];
  bit   lat_seen = 1'b0;

  mul32_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: compare every presented product against the scoreboard head.
  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got p=%h with empty scoreboard", p);
      end else begin
        chk("product", p, sb[0].prod);
        if (!lat_seen) begin
          chk("latency", 64'(cyc - sb[0].t0), 64'(sb[0].lat));
          lat_seen = 1'b1;
        end
        if (out_ready) begin
          void'(sb.pop_front());
          lat_seen = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [31:0] va, input logic [31:0] vb,
                      input logic [63:0] vp, input int lat_full, input int lat_early);
    exp_t e;
    int   n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    a = va;
    b = vb;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    e.prod = vp;
`ifdef MUL32_EARLY_TERM_EN
    e.lat = lat_early;
`else
    e.lat = lat_full;
`endif
    e.t0 = cyc;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int n;
    // Reset state
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_p", p, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed products
    send(32'h0000_FFFF, 32'hFFFF_0000, 64'h0000_FFFE_0001_0000, 32, 32);
    #1 chk("busy_calc", 64'(busy), 64'd1);
    drain();
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 32, 32);
    drain();
    send(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 32, 18);
    drain();

    // Backpressure: hold result while new operands are offered
    out_ready = 1'b0;
    send(32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780, 32, 6);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    a = 32'hAAAA_AAAA;
    b = 32'h5555_5555;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_valid_held", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 64'(out_valid), 64'd0);
    chk("bp_in_ready_next", 64'(in_ready), 64'd1);
    chk("bp_queue_empty", 64'(sb.size()), 64'd0);

    // Reset in the middle of an operation (long multiplier keeps it busy)
    send(32'h0000_DEAD, 32'hFFFF_FFFF, 64'h0000_DEAC_FFFF_2153, 32, 32);
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    sb.delete();
    lat_seen = 1'b0;
    #1;
    chk("mid_rst_p", p, 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    send(32'd7, 32'd6, 64'd42, 32, 4);
    drain();

    // Early-termination boundary cases (full latency without the macro)
    send(32'd5, 32'd3, 64'd15, 32, 3);
    drain();
    send(32'd9, 32'd0, 64'd0, 32, 1);
    drain();
    send(32'd3, 32'h8000_0000, 64'h0000_0001_8000_0000, 32, 32);
    drain();

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
